// File: rtl/operand_fwd_unit.sv
// Operand forwarding unit for the decode/execute boundary.
// Picks each source operand from EX, MEM, WB or the register file (in that
// priority order), detects load-use hazards against the EX stage, inserts a
// one-cycle bubble for them, and presents the forwarded operands to EX through
// a registered valid/ready output stage. Also counts stalls in a saturating
// counter.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The sender holds valid and its payload steady until that edge. ready
// may depend on the receiver's own state, but valid never depends on ready.
// This holds on the input side (id_valid/id_ready) and on the output side
// (out_valid/out_ready).
module operand_fwd_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic              ex_wr_en,
  input  logic              ex_is_load,
  input  logic [ADDR_W-1:0] ex_wr_addr,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_wr_en,
  input  logic [ADDR_W-1:0] mem_wr_addr,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_wr_en,
  input  logic [ADDR_W-1:0] wb_wr_addr,
  input  logic [DATA_W-1:0] wb_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [1:0]        sel_a,
  output logic [1:0]        sel_b,
  output logic              hazard,
  output logic [CNT_W-1:0]  hz_count,
  input  logic              hz_clear
);

  // Source codes carried on sel_a / sel_b.
  localparam logic [1:0] SRC_RF  = 2'b00;
  localparam logic [1:0] SRC_EX  = 2'b01;
  localparam logic [1:0] SRC_MEM = 2'b10;
  localparam logic [1:0] SRC_WB  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // RUN: normal operation. BUBBLE: the stalled load has moved to MEM and EX
  // holds the inserted bubble, so load-use detection is ignored for a cycle.
  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_t;

  state_t state;

  // Per-stage match flags. Register 0 is hard-wired, so it never matches.
  logic rs_nz, rt_nz;
  logic ex_hit_a, mem_hit_a, wb_hit_a;
  logic ex_hit_b, mem_hit_b, wb_hit_b;

  assign rs_nz     = (id_rs != '0);
  assign rt_nz     = (id_rt != '0);

  assign ex_hit_a  = rs_nz && ex_wr_en  && (ex_wr_addr  == id_rs);
  assign mem_hit_a = rs_nz && mem_wr_en && (mem_wr_addr == id_rs);
  assign wb_hit_a  = rs_nz && wb_wr_en  && (wb_wr_addr  == id_rs);

  assign ex_hit_b  = rt_nz && ex_wr_en  && (ex_wr_addr  == id_rt);
  assign mem_hit_b = rt_nz && mem_wr_en && (mem_wr_addr == id_rt);
  assign wb_hit_b  = rt_nz && wb_wr_en  && (wb_wr_addr  == id_rt);

  // Operand A mux: EX beats MEM beats WB beats the register file.
  logic [DATA_W-1:0] nxt_op_a;
  logic [1:0]        nxt_sel_a;

  // Select forwarding source and data for operand A.
  always_comb begin
    nxt_sel_a = SRC_RF;
    nxt_op_a  = id_rs_data;
    if (ex_hit_a) begin
      nxt_sel_a = SRC_EX;
      nxt_op_a  = ex_result;
    end else if (mem_hit_a) begin
      nxt_sel_a = SRC_MEM;
      nxt_op_a  = mem_result;
    end else if (wb_hit_a) begin
      nxt_sel_a = SRC_WB;
      nxt_op_a  = wb_result;
    end
  end

  // Operand B mux, independent of operand A.
  logic [DATA_W-1:0] nxt_op_b;
  logic [1:0]        nxt_sel_b;

  // Select forwarding source and data for operand B.
  always_comb begin
    nxt_sel_b = SRC_RF;
    nxt_op_b  = id_rt_data;
    if (ex_hit_b) begin
      nxt_sel_b = SRC_EX;
      nxt_op_b  = ex_result;
    end else if (mem_hit_b) begin
      nxt_sel_b = SRC_MEM;
      nxt_op_b  = mem_result;
    end else if (wb_hit_b) begin
      nxt_sel_b = SRC_WB;
      nxt_op_b  = wb_result;
    end
  end

  // A load in EX cannot forward its data yet; a consumer must wait one cycle.
  // In BUBBLE the EX slot is the bubble itself, so nothing is flagged.
  logic load_use;
  logic out_free;
  logic fire;
  logic stall_start;

  assign load_use    = ex_is_load && (ex_hit_a || ex_hit_b);
  assign hazard      = (state == RUN) && id_valid && load_use;
  assign out_free    = !out_valid || out_ready;
  assign id_ready    = out_free && !hazard;
  assign fire        = id_valid && id_ready;
  // A stall is only committed when the output stage can move; under
  // backpressure the hazard is simply re-evaluated on the next cycle.
  assign stall_start = hazard && out_free;

  // Stall sequencer: one bubble cycle per committed load-use hazard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (stall_start) state <= BUBBLE;
        BUBBLE:  state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // Saturating stall counter; a clear wins over a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hz_count <= '0;
    end else if (hz_clear) begin
      hz_count <= '0;
    end else if (stall_start && (hz_count != CNT_MAX)) begin
      hz_count <= hz_count + CNT_ONE;
    end
  end

  // Output register stage: load on fire, drop valid once consumed, otherwise
  // hold everything so a stalled EX sees a stable payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      sel_a     <= SRC_RF;
      sel_b     <= SRC_RF;
    end else if (fire) begin
      out_valid <= 1'b1;
      op_a      <= nxt_op_a;
      op_b      <= nxt_op_b;
      sel_a     <= nxt_sel_a;
      sel_b     <= nxt_sel_b;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fwd_unit.sv
// Self-checking bench for operand_fwd_unit: vector table of forwarding cases,
// a randomised forwarding sweep, and hand-written load-use, backpressure,
// counter saturation and reset-during-stall sequences.
module tb_operand_fwd_unit;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int PW = 2 * DW + 4;

  logic          clk;
  logic          rst_n;
  logic          id_valid;
  logic          id_ready;
  logic [AW-1:0] id_rs, id_rt;
  logic [DW-1:0] id_rs_data, id_rt_data;
  logic          ex_wr_en, ex_is_load;
  logic [AW-1:0] ex_wr_addr;
  logic [DW-1:0] ex_result;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_result;
  logic          wb_wr_en;
  logic [AW-1:0] wb_wr_addr;
  logic [DW-1:0] wb_result;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] op_a, op_b;
  logic [1:0]    sel_a, sel_b;
  logic          hazard;
  logic [CW-1:0] hz_count;
  logic          hz_clear;

  int total = 0;
  int bad   = 0;

  logic [PW-1:0] exp_q[$];

  typedef struct {
    logic [AW-1:0] rs, rt;
    logic [DW-1:0] rs_data, rt_data;
    logic          ex_en, ex_ld;
    logic [AW-1:0] ex_addr;
    logic [DW-1:0] ex_res;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_res;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_res;
    logic [DW-1:0] exp_a;
    logic [1:0]    exp_sa;
    logic [DW-1:0] exp_b;
    logic [1:0]    exp_sb;
  } vec_t;

  vec_t vecs[8];

  operand_fwd_unit #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_data (id_rs_data),
    .id_rt_data (id_rt_data),
    .ex_wr_en   (ex_wr_en),
    .ex_is_load (ex_is_load),
    .ex_wr_addr (ex_wr_addr),
    .ex_result  (ex_result),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_addr(mem_wr_addr),
    .mem_result (mem_result),
    .wb_wr_en   (wb_wr_en),
    .wb_wr_addr (wb_wr_addr),
    .wb_result  (wb_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .sel_a      (sel_a),
    .sel_b      (sel_b),
    .hazard     (hazard),
    .hz_count   (hz_count),
    .hz_clear   (hz_clear)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Compare the registered output against the oldest expected entry.
  task automatic pop_chk(input string name);
    logic [PW-1:0] e;
    chk({name, " valid"}, 80'(out_valid), 80'd1);
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: got output want empty queue entry", name);
    end else begin
      total--;
      e = exp_q.pop_front();
      chk(name, 80'({op_a, op_b, sel_a, sel_b}), 80'(e));
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [1:0] sa, input logic [1:0] sb);
    exp_q.push_back({a, b, sa, sb});
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rs_data = 0; id_rt_data = 0;
    ex_wr_en = 0; ex_is_load = 0; ex_wr_addr = 0; ex_result = 0;
    mem_wr_en = 0; mem_wr_addr = 0; mem_result = 0;
    wb_wr_en = 0; wb_wr_addr = 0; wb_result = 0;
  endtask

  // Drive a load-use pattern: EX holds a load to r7, decode reads r7 as rs.
  task automatic drive_load_use(input logic [DW-1:0] ex_val);
    idle();
    id_valid = 1; id_rs = 7; id_rs_data = 32'h0000_0777;
    id_rt = 2; id_rt_data = 32'h0000_0022;
    ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 7; ex_result = ex_val;
  endtask

  task automatic apply_vec(input vec_t v);
    id_valid = 1; out_ready = 1; hz_clear = 0;
    id_rs = v.rs; id_rt = v.rt; id_rs_data = v.rs_data; id_rt_data = v.rt_data;
    ex_wr_en = v.ex_en; ex_is_load = v.ex_ld; ex_wr_addr = v.ex_addr; ex_result = v.ex_res;
    mem_wr_en = v.mem_en; mem_wr_addr = v.mem_addr; mem_result = v.mem_res;
    wb_wr_en = v.wb_en; wb_wr_addr = v.wb_addr; wb_result = v.wb_res;
  endtask

  // Reference forwarding choice for one operand: {source code, data}.
  function automatic logic [DW+1:0] fwd_model(
    input logic [AW-1:0] src, input logic [DW-1:0] rf);
    if (src == 0) return {2'b00, rf};
    if (ex_wr_en && ex_wr_addr == src) return {2'b01, ex_result};
    if (mem_wr_en && mem_wr_addr == src) return {2'b10, mem_result};
    if (wb_wr_en && wb_wr_addr == src) return {2'b11, wb_result};
    return {2'b00, rf};
  endfunction

  initial begin
    logic [DW+1:0] ma, mb;

    //          rs  rt  rs_data        rt_data        exE ld exA ex_res        mE mA  mem_res       wE wA  wb_res        exp_a         sa     exp_b         sb
    vecs[0] = '{5'd3, 5'd4, 32'h0000_0033, 32'h0000_0044, 1, 0, 5'd3, 32'hAAAA_0000, 1, 5'd3, 32'hBBBB_0000, 0, 5'd0, 32'h0, 32'hAAAA_0000, 2'b01, 32'h0000_0044, 2'b00};
    vecs[1] = '{5'd0, 5'd0, 32'h0000_00D0, 32'h0000_00D1, 1, 0, 5'd0, 32'hEEEE_0000, 1, 5'd0, 32'hEEEE_0001, 1, 5'd0, 32'hEEEE_0002, 32'h0000_00D0, 2'b00, 32'h0000_00D1, 2'b00};
    vecs[2] = '{5'd5, 5'd6, 32'h0000_0055, 32'h0000_0066, 0, 0, 5'd0, 32'h0, 1, 5'd6, 32'hCCCC_0006, 1, 5'd5, 32'hDDDD_0005, 32'hDDDD_0005, 2'b11, 32'hCCCC_0006, 2'b10};
    vecs[3] = '{5'd9, 5'd9, 32'h0000_0099, 32'h0000_0098, 0, 0, 5'd9, 32'h0, 1, 5'd9, 32'h9999_0010, 1, 5'd9, 32'h9999_0011, 32'h9999_0010, 2'b10, 32'h9999_0010, 2'b10};
    vecs[4] = '{5'd10, 5'd11, 32'h0000_00AA, 32'h0000_00BB, 1, 0, 5'd11, 32'h1111_0B0B, 1, 5'd10, 32'h1111_0A0A, 0, 5'd0, 32'h0, 32'h1111_0A0A, 2'b10, 32'h1111_0B0B, 2'b01};
    vecs[5] = '{5'd13, 5'd14, 32'h1300_0013, 32'h1400_0014, 1, 0, 5'd15, 32'h5, 1, 5'd16, 32'h6, 1, 5'd12, 32'h7, 32'h1300_0013, 2'b00, 32'h1400_0014, 2'b00};
    vecs[6] = '{5'd31, 5'd31, 32'h3100_0000, 32'h3100_0001, 1, 0, 5'd30, 32'h3000_0000, 0, 5'd31, 32'h0, 1, 5'd31, 32'hF1F1_F1F1, 32'hF1F1_F1F1, 2'b11, 32'hF1F1_F1F1, 2'b11};
    vecs[7] = '{5'd1, 5'd2, 32'h0000_0011, 32'h0000_0022, 1, 0, 5'd2, 32'h2222_EEEE, 1, 5'd2, 32'h2222_AAAA, 1, 5'd2, 32'h2222_BBBB, 32'h0000_0011, 2'b00, 32'h2222_EEEE, 2'b01};

    // Reset values, asynchronously before any clock edge.
    idle(); out_ready = 1; hz_clear = 0; rst_n = 0;
    #2;
    chk("rst out_valid", 80'(out_valid), 80'd0);
    chk("rst ops", 80'({op_a, op_b, sel_a, sel_b}), 80'd0);
    chk("rst hz_count", 80'(hz_count), 80'd0);
    @(negedge clk); rst_n = 1;

    // Forwarding table.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      apply_vec(vecs[i]);
      push_exp(vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_sa, vecs[i].exp_sb);
      #1;
      chk($sformatf("vec%0d id_ready", i), 80'(id_ready), 80'd1);
      @(posedge clk); #1;
      pop_chk($sformatf("vec%0d ops", i));
    end

    // Random forwarding sweep on a small address range to force collisions.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      idle(); id_valid = 1; out_ready = 1;
      id_rs = AW'($urandom_range(0, 3)); id_rt = AW'($urandom_range(0, 3));
      id_rs_data = $urandom; id_rt_data = $urandom;
      ex_wr_en = 1'($urandom_range(0, 1)); ex_wr_addr = AW'($urandom_range(0, 3)); ex_result = $urandom;
      mem_wr_en = 1'($urandom_range(0, 1)); mem_wr_addr = AW'($urandom_range(0, 3)); mem_result = $urandom;
      wb_wr_en = 1'($urandom_range(0, 1)); wb_wr_addr = AW'($urandom_range(0, 3)); wb_result = $urandom;
      ma = fwd_model(id_rs, id_rs_data);
      mb = fwd_model(id_rt, id_rt_data);
      push_exp(ma[DW-1:0], mb[DW-1:0], ma[DW+1:DW], mb[DW+1:DW]);
      #1;
      chk($sformatf("rnd%0d id_ready", i), 80'(id_ready), 80'd1);
      @(posedge clk); #1;
      pop_chk($sformatf("rnd%0d ops", i));
    end

    // Load-use on rt=7: one stall cycle, then the load data arrives from MEM.
    @(negedge clk);
    idle(); out_ready = 1; id_valid = 1;
    id_rs = 1; id_rs_data = 32'h0000_0101; id_rt = 7; id_rt_data = 32'h0000_0707;
    ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 7; ex_result = 32'h0000_DEAD;
    #1;
    chk("lu hazard", 80'(hazard), 80'd1);
    chk("lu id_ready", 80'(id_ready), 80'd0);
    @(posedge clk); #1;
    chk("lu drained", 80'(out_valid), 80'd0);
    chk("lu hz_count", 80'(hz_count), 80'd1);
    @(negedge clk);
    ex_wr_en = 0; ex_is_load = 0;
    mem_wr_en = 1; mem_wr_addr = 7; mem_result = 32'h1234_5678;
    push_exp(32'h0000_0101, 32'h1234_5678, 2'b00, 2'b10);
    #1;
    chk("lu bubble hazard", 80'(hazard), 80'd0);
    chk("lu bubble id_ready", 80'(id_ready), 80'd1);
    @(posedge clk); #1;
    pop_chk("lu fire");
    chk("lu hz_count hold", 80'(hz_count), 80'd1);

    // Detection is masked in BUBBLE even if EX still shows the load.
    @(negedge clk);
    drive_load_use(32'h0E0E_0E0E);
    #1;
    chk("mask hazard run", 80'(hazard), 80'd1);
    @(posedge clk); #1;
    chk("mask hz_count", 80'(hz_count), 80'd2);
    @(negedge clk); #1;
    chk("mask hazard bubble", 80'(hazard), 80'd0);
    chk("mask id_ready", 80'(id_ready), 80'd1);
    push_exp(32'h0E0E_0E0E, 32'h0000_0022, 2'b01, 2'b00);
    @(posedge clk); #1;
    pop_chk("mask fire");
    @(negedge clk); #1;
    chk("mask back to run", 80'(hazard), 80'd1);
    idle();

    // Backpressure: payload frozen for three cycles while inputs churn.
    @(negedge clk);
    idle(); out_ready = 1; id_valid = 1;
    id_rs = 4; id_rs_data = 32'h0000_4444; id_rt = 5; id_rt_data = 32'h0000_5555;
    wb_wr_en = 1; wb_wr_addr = 5; wb_result = 32'h0000_5A5A;
    push_exp(32'h0000_4444, 32'h0000_5A5A, 2'b00, 2'b11);
    @(posedge clk); #1;
    pop_chk("bp load");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 0; id_valid = 1;
      id_rs = AW'($urandom_range(1, 31)); id_rt = AW'($urandom_range(1, 31));
      id_rs_data = $urandom; id_rt_data = $urandom;
      ex_wr_en = 1; ex_is_load = 0; ex_wr_addr = id_rs; ex_result = $urandom;
      #1;
      chk($sformatf("bp%0d id_ready", i), 80'(id_ready), 80'd0);
      @(posedge clk); #1;
      chk($sformatf("bp%0d hold", i), 80'({out_valid, op_a, op_b, sel_a, sel_b}),
          80'({1'b1, 32'h0000_4444, 32'h0000_5A5A, 2'b00, 2'b11}));
    end
    @(negedge clk);
    idle(); out_ready = 1;
    @(posedge clk); #1;
    chk("bp drain valid", 80'(out_valid), 80'd0);
    chk("bp drain hold", 80'({op_a, op_b, sel_a, sel_b}),
        80'({32'h0000_4444, 32'h0000_5A5A, 2'b00, 2'b11}));

    // Hazard under backpressure: no stall committed until EX can move.
    @(negedge clk);
    idle(); out_ready = 1; id_valid = 1; id_rs = 3; id_rs_data = 32'h0000_0088;
    push_exp(32'h0000_0088, 32'h0, 2'b00, 2'b00);
    @(posedge clk); #1;
    pop_chk("hbp load");
    @(negedge clk);
    drive_load_use(32'h0);
    out_ready = 0;
    #1;
    chk("hbp hazard", 80'(hazard), 80'd1);
    @(posedge clk); #1;
    chk("hbp no count", 80'(hz_count), 80'd2);
    chk("hbp valid hold", 80'(out_valid), 80'd1);
    @(negedge clk);
    out_ready = 1;
    #1;
    chk("hbp hazard again", 80'(hazard), 80'd1);
    @(posedge clk); #1;
    chk("hbp count", 80'(hz_count), 80'd3);
    @(negedge clk);
    idle(); id_valid = 1; id_rs = 7; id_rs_data = 32'h0000_0777;
    mem_wr_en = 1; mem_wr_addr = 7; mem_result = 32'h8888_0000;
    push_exp(32'h8888_0000, 32'h0, 2'b10, 2'b00);
    @(posedge clk); #1;
    pop_chk("hbp fire");

    // Counter: clear, saturate after 2^CW+2 stalls, clear, clear beats increment.
    @(negedge clk);
    idle(); hz_clear = 1;
    @(posedge clk); #1;
    chk("sat cleared", 80'(hz_count), 80'd0);
    @(negedge clk); hz_clear = 0;
    for (int i = 0; i < (1 << CW) + 2; i++) begin
      @(negedge clk); drive_load_use(32'h0);
      @(negedge clk); idle();
      if (i == 4) chk("sat mid", 80'(hz_count), 80'd5);
    end
    chk("sat all ones", 80'(hz_count), 80'((1 << CW) - 1));
    @(negedge clk); hz_clear = 1;
    @(posedge clk); #1;
    chk("sat clear", 80'(hz_count), 80'd0);
    @(negedge clk); drive_load_use(32'h0); hz_clear = 1;
    @(posedge clk); #1;
    chk("clear precedence", 80'(hz_count), 80'd0);
    @(negedge clk); idle(); hz_clear = 0;

    // Reset asserted mid-cycle while in BUBBLE.
    @(negedge clk);
    idle(); id_valid = 1; id_rs = 3; id_rs_data = 32'h0000_3333; id_rt = 4; id_rt_data = 32'h0000_4444;
    push_exp(32'h0000_3333, 32'h0000_4444, 2'b00, 2'b00);
    @(posedge clk); #1;
    pop_chk("rb load");
    @(negedge clk); drive_load_use(32'h0);
    @(posedge clk); #1;
    chk("rb in bubble count", 80'(hz_count), 80'd1);
    #2; rst_n = 0; #1;
    chk("rb out_valid", 80'(out_valid), 80'd0);
    chk("rb ops", 80'({op_a, op_b, sel_a, sel_b}), 80'd0);
    chk("rb hz_count", 80'(hz_count), 80'd0);
    @(negedge clk); rst_n = 1;
    #1;
    chk("rb run hazard", 80'(hazard), 80'd1);
    @(posedge clk); #1;
    chk("rb run count", 80'(hz_count), 80'd1);
    @(negedge clk); idle();
    @(posedge clk); #1;

    chk("queue empty", 80'(exp_q.size()), 80'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_fwd_unit.md
OPERAND_FWD_UNIT -- requirements
Module: operand_fwd_unit

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, operand/result data width.
REQ-002 SHALL provide parameter ADDR_W, default 5, register address width.
REQ-003 SHALL provide parameter CNT_W, default 16, hazard counter width.
REQ-004 SHALL use one clock (clk, rising edge) and asynchronous active-low reset rst_n; polarity and synchronicity fixed.
REQ-005 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- id_valid  in  1  decode stage offers operands
- id_ready  out  1  unit accepts operands this cycle
- id_rs, id_rt  in  ADDR_W  source register addresses
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- ex_wr_en, ex_is_load  in  1  EX-stage writes a register / is a load
- ex_wr_addr  in  ADDR_W  EX-stage destination
- ex_result  in  DATA_W  EX-stage ALU result
- mem_wr_en  in  1  MEM-stage writes a register
- mem_wr_addr  in  ADDR_W  MEM-stage destination
- mem_result  in  DATA_W  MEM-stage result (load data or ALU)
- wb_wr_en  in  1  WB-stage writes a register
- wb_wr_addr  in  ADDR_W  WB-stage destination
- wb_result  in  DATA_W  WB-stage result
- out_valid  out  1  registered operands valid
- out_ready  in  1  EX stage accepts operands
- op_a, op_b  out  DATA_W  registered forwarded operands
- sel_a, sel_b  out  2  registered source code: 00 regfile, 01 EX, 10 MEM, 11 WB
- hazard  out  1  combinational load-use stall indicator
- hz_count  out  CNT_W  saturating load-use stall count
- hz_clear  in  1  synchronous clear of hz_count

Function
REQ-006 SHALL select each operand independently with priority EX > MEM > WB > regfile; a stage matches when its wr_en=1 and wr_addr equals the source address.
REQ-007 SHALL never forward for source address 0; address 0 always selects regfile data.
REQ-008 SHALL, on an EX match with ex_is_load=1 and id_valid=1, in state RUN, assert hazard in that cycle.
REQ-009 SHALL drive id_ready = (!out_valid || out_ready) && !hazard.
REQ-010 SHALL accept operands (fire) when id_valid && id_ready; on fire, op_a/op_b/sel_a/sel_b load the selected values and out_valid=1 on the next edge.
REQ-011 SHALL, when out_valid && out_ready and no fire, clear out_valid on the next edge; op/sel registers hold.
REQ-012 SHALL hold op_a, op_b, sel_a, sel_b, out_valid unchanged while out_valid && !out_ready.
REQ-013 SHALL implement FSM states RUN and BUBBLE; RUN -> BUBBLE on a hazard cycle with (!out_valid || out_ready); BUBBLE -> RUN unconditionally after one cycle; otherwise remain in RUN.
REQ-014 SHALL, in BUBBLE, mask load-use detection (EX holds the inserted bubble) and permit normal fire with forwarding from MEM/WB.
REQ-015 SHALL, when hazard coincides with downstream backpressure, stay in RUN and re-evaluate hazard the next cycle.
REQ-016 SHALL increment hz_count by 1 on each RUN->BUBBLE transition, saturating at all-ones; hz_clear takes precedence over increment.
REQ-017 SHALL produce operand latency of exactly 1 cycle from fire to out_valid, and a load-use stall of exactly 1 cycle.

Reset
REQ-018 SHALL, while rst_n=0, force out_valid=0, op_a=0, op_b=0, sel_a=00, sel_b=00, hz_count=0, state=RUN, independent of clk.
REQ-019 SHALL, on reset asserted mid-stall (BUBBLE), return to RUN with all outputs at reset values; no pending operand is retained.

Verification
REQ-020 Bench SHALL cover: id_rs=3, ex_wr_en=1, ex_wr_addr=3, ex_result=0xAAAA0000, mem also writes 3 -> next cycle op_a=0xAAAA0000, sel_a=01.
REQ-021 Bench SHALL cover: id_rs=0, ex_wr_addr=0, ex_wr_en=1 -> op_a=id_rs_data, sel_a=00.
REQ-022 Bench SHALL cover: ex_is_load=1, ex_wr_addr=7, id_rt=7 -> hazard=1, id_ready=0 one cycle; next cycle load in MEM (mem_wr_addr=7, mem_result=0x12345678) -> fire, op_b=0x12345678, sel_b=10, hz_count=1.
REQ-023 Bench SHALL cover: out_valid=1, out_ready=0 for 3 cycles with changing inputs -> op_a/op_b/sel stable, id_ready=0.
REQ-024 Bench SHALL cover: hz_count preset by 2^CNT_W+2 hazards -> hz_count=all-ones; hz_clear=1 -> 0.
REQ-025 Bench SHALL cover: rst_n low mid-cycle during BUBBLE -> out_valid=0, hz_count=0 immediately, RUN after release.
